// File: rtl/control_mc.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with a handshaked RAM port.
// Optional RAM wait timeout: define CTRL_RAM_TIMEOUT_EN.

`ifndef OP_MOV
`define OP_MOV 4'h0
`define OP_ADD 4'h1
`define OP_SUB 4'h2
`define OP_ASR 4'h3
`define OP_ASL 4'h4
`define OP_OR  4'h5
`define OP_AND 4'h6
`define OP_XOR 4'h7
`define OP_LSL 4'h8
`define OP_LSR 4'h9
`define OP_CND 4'hA
`define OP_CBR 4'hB
`define OP_LD  4'hC
`define OP_LDA 4'hD
`define OP_ST  4'hE
`endif

`ifndef ALU_NOP
`define ALU_NOP 4'h0
`define ALU_MOV 4'h1
`define ALU_ADD 4'h2
`define ALU_SUB 4'h3
`define ALU_ASR 4'h4
`define ALU_ASL 4'h5
`define ALU_OR  4'h6
`define ALU_AND 4'h7
`define ALU_XOR 4'h8
`define ALU_LSL 4'h9
`define ALU_LSR 4'hA
`define ALU_CND 4'hB
`endif

`ifndef RAM_NONE
`define RAM_NONE  2'd0
`define RAM_READ  2'd1
`define RAM_WRITE 2'd2
`endif

module control_mc #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int INST_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [INST_W-1:0] i_inst,
  input  logic [REG_W-1:0]  i_reg0,
  input  logic [REG_W-1:0]  i_reg1,
  input  logic [DATA_W-1:0] i_val_reg0,
  input  logic [DATA_W-1:0] i_val_reg1,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_pc_inc,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic [DATA_W-1:0] i_ram_rdata,
  input  logic              i_ram_ready,
  output logic [DATA_W-1:0] o_ram_addr,
  output logic [1:0]        o_ram_do,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ir_en,
  output logic              o_pc_en,
  output logic [3:0]        o_alu_do,
  output logic              o_wb_en,
  output logic [REG_W-1:0]  o_wb_reg,
  output logic [DATA_W-1:0] o_wb_val,
  output logic              o_do_jump,
  output logic              o_fault
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t              state_q, state_d;
  logic [INST_W-1:0]   op_q, op_d;
  logic [REG_W-1:0]    reg0_q, reg0_d, reg1_q, reg1_d;
  logic [DATA_W-1:0]   val0_q, val0_d, val1_q, val1_d;
  logic [DATA_W-1:0]   pcinc_q, pcinc_d, alu_q, alu_d, rdata_q, rdata_d;

`ifdef CTRL_RAM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0]   wait_q, wait_d;
`endif

  logic is_ld, is_lda, is_st, is_cbr, is_known;
  assign is_ld    = (op_q == INST_W'(`OP_LD));
  assign is_lda   = (op_q == INST_W'(`OP_LDA));
  assign is_st    = (op_q == INST_W'(`OP_ST));
  assign is_cbr   = (op_q == INST_W'(`OP_CBR));
  assign is_known = (op_q <= INST_W'(`OP_ST));

  function automatic logic [3:0] alu_dec(input logic [INST_W-1:0] op);
    case (op)
      INST_W'(`OP_MOV): return `ALU_MOV;
      INST_W'(`OP_ADD): return `ALU_ADD;
      INST_W'(`OP_SUB): return `ALU_SUB;
      INST_W'(`OP_ASR): return `ALU_ASR;
      INST_W'(`OP_ASL): return `ALU_ASL;
      INST_W'(`OP_OR):  return `ALU_OR;
      INST_W'(`OP_AND): return `ALU_AND;
      INST_W'(`OP_XOR): return `ALU_XOR;
      INST_W'(`OP_LSL): return `ALU_LSL;
      INST_W'(`OP_LSR): return `ALU_LSR;
      INST_W'(`OP_CND): return `ALU_CND;
      default:          return `ALU_NOP;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      reg0_q  <= '0;
      reg1_q  <= '0;
      val0_q  <= '0;
      val1_q  <= '0;
      pcinc_q <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
`ifdef CTRL_RAM_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      reg0_q  <= reg0_d;
      reg1_q  <= reg1_d;
      val0_q  <= val0_d;
      val1_q  <= val1_d;
      pcinc_q <= pcinc_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
`ifdef CTRL_RAM_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  // Outputs are gated by i_rst_n so an asserted reset quiets the RAM port in the same cycle.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    reg0_d      = reg0_q;
    reg1_d      = reg1_q;
    val0_d      = val0_q;
    val1_d      = val1_q;
    pcinc_d     = pcinc_q;
    alu_d       = alu_q;
    rdata_d     = rdata_q;
`ifdef CTRL_RAM_TIMEOUT_EN
    wait_d      = wait_q;
`endif
    o_ram_addr  = '0;
    o_ram_do    = `RAM_NONE;
    o_ram_wdata = '0;
    o_ir_en     = 1'b0;
    o_pc_en     = 1'b0;
    o_alu_do    = `ALU_NOP;
    o_wb_en     = 1'b0;
    o_wb_reg    = '0;
    o_wb_val    = '0;
    o_do_jump   = 1'b0;
    o_fault     = 1'b0;

    if (i_rst_n) begin
      case (state_q)
        S_FETCH: begin
          o_ram_do   = `RAM_READ;
          o_ram_addr = i_pc;
          if (i_ram_ready) begin
            o_ir_en = 1'b1;
            o_pc_en = 1'b1;
            op_d    = i_inst;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          reg0_d  = i_reg0;
          reg1_d  = i_reg1;
          val0_d  = i_val_reg0;
          val1_d  = i_val_reg1;
          pcinc_d = i_pc_inc;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          o_alu_do = alu_dec(op_q);
          alu_d    = i_alu_out;
          if (is_ld || is_lda || is_st) begin
            state_d = S_MEM;
`ifdef CTRL_RAM_TIMEOUT_EN
            wait_d  = '0;
`endif
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          if (is_st) begin
            o_ram_do    = `RAM_WRITE;
            o_ram_addr  = val1_q;
            o_ram_wdata = val0_q;
          end else begin
            o_ram_do    = `RAM_READ;
            o_ram_addr  = is_lda ? pcinc_q : val0_q;
          end
          if (i_ram_ready) begin
            if (!is_st) rdata_d = i_ram_rdata;
            o_pc_en = is_lda;
            state_d = S_WB;
          end
        end
        S_WB: begin
          o_do_jump = is_cbr && (val0_q != '0);
          // The jump target is loaded through the PC enable when the branch is taken.
          o_pc_en   = o_do_jump;
          o_wb_en   = is_known && !is_st && !(is_cbr && val0_q == '0);
          o_wb_reg  = is_cbr ? reg0_q : reg1_q;
          o_wb_val  = is_cbr ? pcinc_q : ((is_ld || is_lda) ? rdata_q : alu_q);
          state_d   = S_FETCH;
`ifdef CTRL_RAM_TIMEOUT_EN
          wait_d    = '0;
`endif
        end
        default: state_d = S_FETCH;
      endcase

`ifdef CTRL_RAM_TIMEOUT_EN
      if ((state_q == S_FETCH || state_q == S_MEM) && !i_ram_ready) begin
        if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          o_fault     = 1'b1;
          o_ram_do    = `RAM_NONE;
          o_ram_addr  = '0;
          o_ram_wdata = '0;
          state_d     = S_FETCH;
          wait_d      = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_control_mc.sv
// Directed bench for control_mc: reset, ALU op, loads, stores, branches, unknown opcode, RAM waits.
module tb_control_mc;
  localparam int DW = 32, RW = 5, IW = 4;
  localparam logic [3:0] OP_ADD = 4'h1, OP_CBR = 4'hB, OP_LD = 4'hC, OP_LDA = 4'hD,
                         OP_ST = 4'hE, OP_BAD = 4'hF;
  localparam logic [3:0] A_NOP = 4'h0, A_ADD = 4'h2;
  localparam logic [1:0] R_NONE = 2'd0, R_READ = 2'd1, R_WRITE = 2'd2;

  logic          i_clk = 1'b0, i_rst_n;
  logic [IW-1:0] i_inst;
  logic [RW-1:0] i_reg0, i_reg1;
  logic [DW-1:0] i_val_reg0, i_val_reg1, i_pc, i_pc_inc, i_alu_out, i_ram_rdata;
  logic          i_ram_ready;
  logic [DW-1:0] o_ram_addr, o_ram_wdata, o_wb_val;
  logic [1:0]    o_ram_do;
  logic [3:0]    o_alu_do;
  logic [RW-1:0] o_wb_reg;
  logic          o_ir_en, o_pc_en, o_wb_en, o_do_jump, o_fault;

  int nvec = 0, nerr = 0;

  control_mc #(.DATA_W(DW), .REG_W(RW), .INST_W(IW), .TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inst(i_inst), .i_reg0(i_reg0), .i_reg1(i_reg1),
    .i_val_reg0(i_val_reg0), .i_val_reg1(i_val_reg1), .i_pc(i_pc), .i_pc_inc(i_pc_inc),
    .i_alu_out(i_alu_out), .i_ram_rdata(i_ram_rdata), .i_ram_ready(i_ram_ready),
    .o_ram_addr(o_ram_addr), .o_ram_do(o_ram_do), .o_ram_wdata(o_ram_wdata),
    .o_ir_en(o_ir_en), .o_pc_en(o_pc_en), .o_alu_do(o_alu_do), .o_wb_en(o_wb_en),
    .o_wb_reg(o_wb_reg), .o_wb_val(o_wb_val), .o_do_jump(o_do_jump), .o_fault(o_fault));

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_inst = '0; i_reg0 = '0; i_reg1 = '0; i_val_reg0 = '0; i_val_reg1 = '0;
    i_pc = 32'h10; i_pc_inc = 32'h11; i_alu_out = '0; i_ram_rdata = '0; i_ram_ready = 1'b0;
    #2;
    nvec++; if (o_ram_do !== R_NONE) begin nerr++; $display("FAIL rst_ram_do got %0d want 0", o_ram_do); end
    nvec++; if (o_ram_addr !== 32'h0) begin nerr++; $display("FAIL rst_addr got %h want 0", o_ram_addr); end
    nvec++; if ({o_ir_en, o_pc_en, o_wb_en, o_do_jump, o_fault} !== 5'b0) begin nerr++; $display("FAIL rst_strobes got %b want 0", {o_ir_en, o_pc_en, o_wb_en, o_do_jump, o_fault}); end
    tick(); i_rst_n = 1'b1; #1;
    nvec++; if (o_ram_do !== R_READ || o_ram_addr !== 32'h10) begin nerr++; $display("FAIL rst_fetch got do=%0d addr=%h want 1/10", o_ram_do, o_ram_addr); end
    nvec++; if (o_ir_en !== 1'b0 || o_pc_en !== 1'b0) begin nerr++; $display("FAIL rst_fetch_wait got ir=%b pc=%b want 0/0", o_ir_en, o_pc_en); end
  endtask

  task automatic test_add();
    i_inst = OP_ADD; i_ram_ready = 1'b1; i_reg0 = 5'd1; i_reg1 = 5'd3; i_alu_out = 32'h7; #1;
    nvec++; if (o_ir_en !== 1'b1 || o_pc_en !== 1'b1) begin nerr++; $display("FAIL add_c1 got ir=%b pc=%b want 1/1", o_ir_en, o_pc_en); end
    tick();
    nvec++; if (o_pc_en !== 1'b0 || o_ram_do !== R_NONE) begin nerr++; $display("FAIL add_c2 got pc=%b do=%0d want 0/0", o_pc_en, o_ram_do); end
    tick();
    nvec++; if (o_alu_do !== A_ADD || o_pc_en !== 1'b0) begin nerr++; $display("FAIL add_c3 got alu=%0d pc=%b want 2/0", o_alu_do, o_pc_en); end
    tick();
    nvec++; if (o_wb_en !== 1'b1 || o_wb_reg !== 5'd3 || o_wb_val !== 32'h7) begin nerr++; $display("FAIL add_wb got en=%b reg=%0d val=%h want 1/3/7", o_wb_en, o_wb_reg, o_wb_val); end
    nvec++; if (o_pc_en !== 1'b0 || o_do_jump !== 1'b0 || o_ram_do !== R_NONE) begin nerr++; $display("FAIL add_c4 got pc=%b jmp=%b do=%0d want 0/0/0", o_pc_en, o_do_jump, o_ram_do); end
    tick();
  endtask

  task automatic test_ld();
    i_inst = OP_LD; i_ram_ready = 1'b1; i_reg1 = 5'd4; i_val_reg0 = 32'h40; #1;
    tick(); tick();
    i_val_reg0 = 32'h99; #1;
    nvec++; if (o_alu_do !== A_NOP) begin nerr++; $display("FAIL ld_alu got %0d want 0", o_alu_do); end
    tick();
    i_ram_ready = 1'b0; i_ram_rdata = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) i_ram_ready = 1'b1;
      #1;
      nvec++; if (o_ram_do !== R_READ || o_ram_addr !== 32'h40) begin nerr++; $display("FAIL ld_mem%0d got do=%0d addr=%h want 1/40", k, o_ram_do, o_ram_addr); end
      if (k < 3) tick();
    end
    tick();
    nvec++; if (o_wb_en !== 1'b1 || o_wb_reg !== 5'd4 || o_wb_val !== 32'hDEADBEEF) begin nerr++; $display("FAIL ld_wb got en=%b reg=%0d val=%h want 1/4/deadbeef", o_wb_en, o_wb_reg, o_wb_val); end
    tick();
  endtask

  task automatic test_lda();
    i_inst = OP_LDA; i_ram_ready = 1'b1; i_reg1 = 5'd6; i_pc_inc = 32'h21; i_ram_rdata = 32'hCAFE; #1;
    tick(); tick(); i_pc_inc = 32'h77; tick(); #1;
    nvec++; if (o_ram_do !== R_READ || o_ram_addr !== 32'h21 || o_pc_en !== 1'b1) begin nerr++; $display("FAIL lda_mem got do=%0d addr=%h pc=%b want 1/21/1", o_ram_do, o_ram_addr, o_pc_en); end
    tick();
    nvec++; if (o_wb_en !== 1'b1 || o_wb_reg !== 5'd6 || o_wb_val !== 32'hCAFE) begin nerr++; $display("FAIL lda_wb got en=%b reg=%0d val=%h want 1/6/cafe", o_wb_en, o_wb_reg, o_wb_val); end
    tick();
  endtask

  task automatic test_cbr(input logic [31:0] v0, input logic jmp);
    i_inst = OP_CBR; i_ram_ready = 1'b1; i_reg0 = 5'd2; i_reg1 = 5'd9; i_val_reg0 = v0; i_pc_inc = 32'h11; #1;
    tick(); tick(); i_pc_inc = 32'h55; i_val_reg0 = ~v0; tick();
    nvec++; if (o_do_jump !== jmp || o_wb_en !== jmp) begin nerr++; $display("FAIL cbr_%0d got jmp=%b en=%b want %b/%b", v0, o_do_jump, o_wb_en, jmp, jmp); end
    if (jmp) begin
      nvec++; if (o_wb_reg !== 5'd2 || o_wb_val !== 32'h11) begin nerr++; $display("FAIL cbr_link got reg=%0d val=%h want 2/11", o_wb_reg, o_wb_val); end
    end
    tick();
  endtask

  task automatic test_st_unknown();
    i_inst = OP_ST; i_ram_ready = 1'b1; i_val_reg1 = 32'h80; i_val_reg0 = 32'h1234; #1;
    tick(); tick(); tick();
    nvec++; if (o_ram_do !== R_WRITE || o_ram_addr !== 32'h80 || o_ram_wdata !== 32'h1234 || o_wb_en !== 1'b0) begin nerr++; $display("FAIL st_mem got do=%0d addr=%h wd=%h en=%b want 2/80/1234/0", o_ram_do, o_ram_addr, o_ram_wdata, o_wb_en); end
    tick();
    nvec++; if (o_wb_en !== 1'b0 || o_ram_do !== R_NONE) begin nerr++; $display("FAIL st_wb got en=%b do=%0d want 0/0", o_wb_en, o_ram_do); end
    tick();
    i_inst = OP_BAD; #1;
    tick(); tick();
    nvec++; if (o_alu_do !== A_NOP) begin nerr++; $display("FAIL bad_alu got %0d want 0", o_alu_do); end
    tick();
    nvec++; if (o_ram_do !== R_NONE || o_wb_en !== 1'b0 || o_pc_en !== 1'b0) begin nerr++; $display("FAIL bad_wb got do=%0d en=%b pc=%b want 0/0/0", o_ram_do, o_wb_en, o_pc_en); end
    tick();
    nvec++; if (o_ram_do !== R_READ) begin nerr++; $display("FAIL bad_next got do=%0d want 1 (fetch)", o_ram_do); end
  endtask

  task automatic test_timeout();
    i_inst = OP_ST; i_ram_ready = 1'b1; i_val_reg1 = 32'h84; i_val_reg0 = 32'h5; #1;
    tick(); tick(); tick();
    i_ram_ready = 1'b0; #1;
`ifdef CTRL_RAM_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      nvec++; if (o_fault !== 1'b0 || o_ram_do !== R_WRITE) begin nerr++; $display("FAIL to_wait%0d got f=%b do=%0d want 0/2", k, o_fault, o_ram_do); end
      tick();
    end
    nvec++; if (o_fault !== 1'b1 || o_ram_do !== R_NONE || o_pc_en !== 1'b0 || o_wb_en !== 1'b0) begin nerr++; $display("FAIL to_fault got f=%b do=%0d pc=%b en=%b want 1/0/0/0", o_fault, o_ram_do, o_pc_en, o_wb_en); end
    tick();
    nvec++; if (o_fault !== 1'b0 || o_ram_do !== R_READ || o_wb_en !== 1'b0) begin nerr++; $display("FAIL to_fetch got f=%b do=%0d en=%b want 0/1/0", o_fault, o_ram_do, o_wb_en); end
`else
    for (int k = 1; k <= 20; k++) begin
      nvec++; if (o_fault !== 1'b0 || o_ram_do !== R_WRITE || o_ram_addr !== 32'h84) begin nerr++; $display("FAIL nto_wait%0d got f=%b do=%0d addr=%h want 0/2/84", k, o_fault, o_ram_do, o_ram_addr); end
      tick();
    end
`endif
  endtask

  task automatic test_reset_mid_mem();
    // Whatever state the previous test left, reset and bring an ST into a stalled MEM.
    i_rst_n = 1'b0; #1; i_rst_n = 1'b1; i_ram_ready = 1'b1; i_inst = OP_ST; #1;
    tick(); tick(); tick();
    i_ram_ready = 1'b0; #1;
    nvec++; if (o_ram_do !== R_WRITE) begin nerr++; $display("FAIL rm_pre got do=%0d want 2", o_ram_do); end
    #1; i_rst_n = 1'b0; #1;
    nvec++; if (o_ram_do !== R_NONE || o_ram_addr !== 32'h0 || o_ram_wdata !== 32'h0) begin nerr++; $display("FAIL rm_async got do=%0d addr=%h wd=%h want 0/0/0", o_ram_do, o_ram_addr, o_ram_wdata); end
    tick(); i_rst_n = 1'b1; #1;
    nvec++; if (o_ram_do !== R_READ || {o_ir_en, o_pc_en, o_wb_en, o_fault} !== 4'b0) begin nerr++; $display("FAIL rm_release got do=%0d str=%b want 1/0", o_ram_do, {o_ir_en, o_pc_en, o_wb_en, o_fault}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld();
    test_lda();
    test_cbr(32'h5, 1'b1);
    test_cbr(32'h0, 1'b0);
    test_st_unknown();
    test_timeout();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
